apb_master_bridge: RTL and testbench

APB initiator that converts a simple valid/ready request port (core or DMA side) into single APB transfers toward peripheral slaves such as the FPU APB block. It drives SETUP and ACCESS phases, honours PREADY wait states, and returns read data plus a per-transfer error to the requester. It is the initiating end of the same APB interface the peripheral slaves respond to.

---
 rtl/apb_master_pkg.sv | 27 ++
 rtl/apb_master_wdog.sv | 53 +++++
 rtl/apb_master_bridge.sv | 198 +++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// -----------------------------------------------------------------------------
// apb_master_pkg
// Shared definitions for the APB initiator bridge:
//   - apb_state_e     : bridge FSM states
//   - APB_DATA_WIDTH  : APB data bus width
//   - ERR_RDATA       : read data returned for writes, errors and aborts
//   - wdog_cnt_width(): width of the optional ACCESS-phase timeout counter
// -----------------------------------------------------------------------------
package apb_master_pkg;

  localparam int unsigned APB_DATA_WIDTH = 32;

  localparam logic [APB_DATA_WIDTH-1:0] ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no transfer, bus parked
    SETUP  = 2'd1,  // PSEL=1, PENABLE=0
    ACCESS = 2'd2,  // PSEL=1, PENABLE=1, waiting for PREADY
    ERRRSP = 2'd3   // local error response for a misaligned request
  } apb_state_e;

  // Counter must be able to hold the value TIMEOUT_CYCLES itself.
  function automatic int unsigned wdog_cnt_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_master_wdog.sv
// -----------------------------------------------------------------------------
// apb_master_wdog
// ACCESS-phase watchdog for the APB initiator. Counts ACCESS cycles in which
// PREADY is low and flags expiry on the cycle in which the count reaches
// TIMEOUT_CYCLES, so the bridge can abort on the following edge.
//
// Ports:
//   CLK      in  clock, rising edge
//   RSTN     in  synchronous active-low reset
//   clr      in  clear the count (asserted on the cycle before ACCESS)
//   inc      in  one more wait cycle in ACCESS
//   expired  out combinational: this wait cycle is number TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module apb_master_wdog
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = wdog_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The increment that would make the count equal TIMEOUT_CYCLES is the
  // expiry point; the bridge leaves ACCESS on that edge, so the counter
  // itself never needs to hold a value past TIMEOUT_CYCLES.
  assign expired = inc && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// APB initiator: turns a valid/ready request port into single APB transfers,
// honours PREADY wait states and returns read data plus an error flag as a
// one-cycle response pulse. Misaligned requests (addr[1:0] != 0) never reach
// the bus and are answered locally with an error.
//
// Optional build macro: APB_MASTER_TIMEOUT_EN
//   When defined, an ACCESS phase that sees TIMEOUT_CYCLES consecutive
//   PREADY-low cycles is aborted with an error response. When undefined,
//   ACCESS waits for PREADY indefinitely.
//
// Ports:
//   CLK, RSTN            clock (rising edge), synchronous active-low reset
//   req_valid/req_ready  request handshake (req_ready is combinational)
//   req_addr/wdata/write request payload, latched on the handshake
//   rsp_valid            one-cycle completion pulse, no backpressure
//   rsp_rdata/rsp_err    response payload, valid with rsp_valid
//   PADDR..PENABLE       registered APB initiator outputs
//   PRDATA/PREADY/PSLVERR APB completer inputs
// -----------------------------------------------------------------------------
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  // request side
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  input  logic                      req_write,
  // response side
  output logic                      rsp_valid,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  // APB initiator
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_state_e                state_q,     state_d;
  logic                      psel_q,      psel_d;
  logic                      penable_q,   penable_d;
  logic                      pwrite_q,    pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q,   rsp_err_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic handshake;
  logic req_aligned;
  logic timeout_expired;

  // A new request can be taken in IDLE, or in the last ACCESS cycle of the
  // current transfer so back-to-back transfers need no idle cycle.
  assign req_ready   = (state_q == IDLE) || ((state_q == ACCESS) && PREADY);
  assign handshake   = req_valid && req_ready;
  assign req_aligned = (req_addr[1:0] == 2'b00);

  // TIMEOUT_CYCLES of zero would make the watchdog expire before any wait;
  // the parameter is meant to be at least 1. Nothing is built for it here.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_cfg_invalid
  end

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .clr     (state_q == SETUP),
    .inc     ((state_q == ACCESS) && !PREADY),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = ERR_RDATA;

    // Payload is captured only on a handshake; otherwise the bus keeps its
    // last values so idle cycles cause no toggling.
    if (handshake) begin
      paddr_d  = req_addr;
      pwdata_d = req_wdata;
      pwrite_d = req_write;
    end

    unique case (state_q)
      IDLE: begin
        penable_d = 1'b0;
        if (handshake) begin
          state_d = req_aligned ? SETUP : ERRRSP;
          psel_d  = req_aligned;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : ERR_RDATA;
          penable_d   = 1'b0;
          if (handshake) begin
            // Chained transfer: PSEL stays high, PENABLE drops for SETUP.
            state_d = req_aligned ? SETUP : ERRRSP;
            psel_d  = req_aligned;
          end else begin
            state_d = IDLE;
            psel_d  = 1'b0;
          end
        end else if (timeout_expired) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end

      ERRRSP: begin
        // The response is registered on the edge leaving ERRRSP, so a
        // misaligned request chained behind an ACCESS completion never
        // collides with that completion's response pulse.
        state_d     = IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
// Self-checking bench for apb_master_bridge. A small APB completer memory sits
// on the bus side; a reference memory updated from the request side predicts
// every response. Covers directed cases, back-to-back transfers, reset during
// ACCESS, the ACCESS timeout (APB_MASTER_TIMEOUT_EN) or indefinite wait
// (default build), and randomized traffic.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int unsigned TMO = 4;

  logic        CLK;
  logic        RSTN;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_cmp = 0;
  int n_mis = 0;
  int n_xfer = 0;

  // Completer-side storage (written from the bus) and reference storage
  // (written from the request stream); both cover addr[5:2].
  logic [31:0] mem_slave [16] = '{default: 32'h0};
  logic [31:0] mem_ref   [16] = '{default: 32'h0};

  apb_master_bridge #(
    .APB_ADDR_WIDTH (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_write (req_write),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign PRDATA = mem_slave[PADDR[5:2]];

  always @(posedge CLK) begin
    if (RSTN && PSEL && PENABLE && PREADY && PWRITE && !PSLVERR)
      mem_slave[PADDR[5:2]] <= PWDATA;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete transfer from an idle bridge, with cycle-exact checks.
  task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wr, input int waits, input logic slverr);
    logic        aligned;
    int          idx;
    logic        exp_err;
    logic [31:0] exp_rdata;
    aligned = (addr[1:0] == 2'b00);
    idx     = int'(addr[5:2]);
    if (!aligned) begin
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
    end else begin
      exp_err   = slverr;
      exp_rdata = (wr || slverr) ? 32'h0 : mem_ref[idx];
      if (wr && !slverr) mem_ref[idx] = wdata;
    end

    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_write = wr;
    PREADY = 1'b0; PSLVERR = 1'b0;
    check_val("ready_idle", req_ready, 1);
    tick();
    // Scramble the request port to prove the payload was latched.
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);

    if (aligned) begin
      check_val("setup_sel_en", {PSEL, PENABLE}, 2'b10);
      check_val("setup_paddr", PADDR, addr);
      check_val("setup_pwrite", PWRITE, wr);
      check_val("setup_pwdata", PWDATA, wdata);
      check_val("setup_ready", req_ready, 0);
      tick();
      for (int i = 0; i <= waits; i++) begin
        check_val("access_sel_en_rsp", {PSEL, PENABLE, rsp_valid}, 3'b110);
        check_val("access_paddr", PADDR, addr);
        check_val("access_pwdata", PWDATA, wdata);
        PREADY  = (i == waits);
        PSLVERR = (i == waits) ? slverr : 1'($urandom);
        tick();
      end
      PREADY = 1'b0; PSLVERR = 1'b0;
    end else begin
      check_val("mis_psel_rsp", {PSEL, rsp_valid}, 2'b00);
      tick();
    end
    check_val("rsp_valid", rsp_valid, 1);
    check_val("rsp_err", rsp_err, exp_err);
    check_val("rsp_rdata", rsp_rdata, exp_rdata);
    check_val("done_sel_en", {PSEL, PENABLE}, 2'b00);
    tick();
    check_val("rsp_pulse_end", rsp_valid, 0);
    n_xfer++;
    $display("xfer %0d: %s addr=0x%08h wdata=0x%08h waits=%0d slverr=%0b -> err=%0b rdata=0x%08h",
             n_xfer, wr ? "WR" : "RD", addr, wdata, waits, slverr, exp_err, exp_rdata);
  endtask

  // Three chained requests with PREADY high throughout.
  task automatic b2b_test();
    logic [31:0] ba [3];
    logic        bw [3];
    logic [31:0] bd [3];
    logic [31:0] exp_q [$];
    int          k;
    ba = '{32'h1A10_0014, 32'h1A10_0014, 32'h1A10_0018};
    bw = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      bd[i] = $urandom;
      if (bw[i]) begin
        mem_ref[int'(ba[i][5:2])] = bd[i];
        exp_q.push_back(32'h0);
      end else begin
        exp_q.push_back(mem_ref[int'(ba[i][5:2])]);
      end
    end
    PREADY = 1'b1; PSLVERR = 1'b0;
    k = 0;
    req_valid = 1'b1; req_addr = ba[0]; req_wdata = bd[0]; req_write = bw[0];
    for (int c = 0; c < 7; c++) begin
      check_val("b2b_ready", req_ready, (c % 2 == 0));
      tick();
      check_val("b2b_psel", PSEL, (c < 6));
      check_val("b2b_penable", PENABLE, (c % 2 == 1));
      check_val("b2b_rsp_valid", rsp_valid, (c == 2 || c == 4 || c == 6));
      if (c == 2 || c == 4 || c == 6) begin
        check_val("b2b_rsp_err", rsp_err, 0);
        check_val("b2b_rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
      if (c == 0 || c == 2 || c == 4) begin
        check_val("b2b_paddr", PADDR, ba[k]);
        k++;
        if (k < 3) begin
          req_addr = ba[k]; req_wdata = bd[k]; req_write = bw[k];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    PREADY = 1'b0;
    $display("xfer b2b: 3 chained transfers at 0x%08h/0x%08h/0x%08h", ba[0], ba[1], ba[2]);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] exp_rd;
    RSTN = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
    PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) tick();
    check_val("rst_sel_en_wr", {PSEL, PENABLE, PWRITE}, 3'b000);
    check_val("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    check_val("rst_paddr", PADDR, 0);
    check_val("rst_pwdata", PWDATA, 0);
    check_val("rst_rdata", rsp_rdata, 0);
    check_val("rst_ready", req_ready, 1);
    RSTN = 1'b1;
    tick();

    // Directed cases.
    do_xfer(32'h1A10_0004, 32'h3F80_0000, 1'b1, 0, 1'b0);
    do_xfer(32'h1A10_0010, 32'h4049_0FDB, 1'b1, 0, 1'b0);
    do_xfer(32'h1A10_0010, 32'h0,         1'b0, 2, 1'b0);
    do_xfer(32'h1A10_0004, 32'h0,         1'b0, 1, 1'b1);
    do_xfer(32'h1A10_0002, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
    do_xfer(32'h1A10_0004, 32'h0,         1'b0, 0, 1'b0);

    b2b_test();
    tick();

    // Reset while ACCESS is stalled.
    req_valid = 1'b1; req_addr = 32'h1A10_001C; req_wdata = 32'h1234_5678; req_write = 1'b1;
    PREADY = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    check_val("prerst_access", {PSEL, PENABLE}, 2'b11);
    RSTN = 1'b0;
    tick();
    check_val("midrst_sel_en_rsp", {PSEL, PENABLE, rsp_valid}, 3'b000);
    check_val("midrst_paddr", PADDR, 0);
    RSTN = 1'b1;
    tick();
    check_val("postrst_rsp", {PSEL, rsp_valid}, 2'b00);
    $display("xfer reset: write to 0x1A10001C abandoned in ACCESS");
    do_xfer(32'h1A10_001C, 32'h0, 1'b0, 0, 1'b0);

    // Long PREADY-low stall.
    a = 32'h1A10_000C;
    exp_rd = mem_ref[3];
    req_valid = 1'b1; req_addr = a; req_wdata = 32'h0; req_write = 1'b0;
    PREADY = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < int'(TMO); i++) begin
      check_val("tmo_wait", {PSEL, PENABLE, rsp_valid}, 3'b110);
      tick();
    end
    check_val("tmo_abort_sel_en", {PSEL, PENABLE}, 2'b00);
    check_val("tmo_abort_rsp", {rsp_valid, rsp_err}, 2'b11);
    check_val("tmo_abort_rdata", rsp_rdata, 0);
    tick();
    check_val("tmo_pulse_end", rsp_valid, 0);
    $display("xfer timeout: read 0x%08h aborted after %0d wait cycles", a, TMO);
`else
    for (int i = 0; i < 100; i++) begin
      check_val("stall_hold", {PSEL, PENABLE, rsp_valid}, 3'b110);
      tick();
    end
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    check_val("stall_rsp", {rsp_valid, rsp_err}, 2'b10);
    check_val("stall_rdata", rsp_rdata, exp_rd);
    tick();
    check_val("stall_pulse_end", rsp_valid, 0);
    $display("xfer stall: read 0x%08h completed after 100 wait cycles", a);
`endif

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      logic [31:0] rd;
      logic        rw;
      logic        se;
      int          wt;
      ra = 32'h1A10_0000 | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      rw = 1'($urandom);
      rd = $urandom;
      wt = int'($urandom_range(0, 3));
      se = ($urandom_range(0, 5) == 0);
      repeat ($urandom_range(0, 2)) tick();
      do_xfer(ra, rd, rw, wt, se);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
